// File: rtl/tilt_motion_ctl.sv
// -----------------------------------------------------------------------------
// tilt_motion_ctl
// Turns per-axis accelerometer tilt readings into ball motion. Each physics
// tick runs a three-stage update per axis: acceleration (dead zone + scaling),
// velocity (integration, saturation, friction) and sub-step position
// accumulation. A step pulse is emitted whenever the position crosses one
// whole step, so larger tilt gives faster, accelerating movement.
//
// Ports
//   clk               system clock
//   reset             synchronous, active-low reset
//   accel_x, accel_y  [8] = direction (1 = increment), [7:0] = tilt magnitude
//   blk_x, blk_y      axis blocked by a wall (level), zeroes v and p
//   x_inc, x_dec      one-cycle step pulses for the X axis
//   y_inc, y_dec      one-cycle step pulses for the Y axis
//   vel_x, vel_y      current velocity, two's complement
//   tick              one-cycle pulse marking each physics update
// -----------------------------------------------------------------------------
module tilt_motion_ctl #(
    parameter int TICK_DIV    = 1000000,
    parameter int DEADZONE    = 8,
    parameter int ACCEL_SHIFT = 3,
    parameter int VMAX        = 127,
    parameter int FRICTION    = 1,
    parameter int FRAC_BITS   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [8:0] accel_x,
    input  logic [8:0] accel_y,
    input  logic       blk_x,
    input  logic       blk_y,
    output logic       x_inc,
    output logic       x_dec,
    output logic       y_inc,
    output logic       y_dec,
    output logic [8:0] vel_x,
    output logic [8:0] vel_y,
    output logic       tick
);

    localparam int                    CW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(TICK_DIV - 1);
    localparam int                    PW       = FRAC_BITS + 2;
    localparam logic signed [PW-1:0]  STEP_P   = PW'(1 << FRAC_BITS);
    localparam logic signed [PW-1:0]  STEP_N   = -STEP_P;
    localparam logic signed [9:0]     VMAX_P   = 10'(VMAX);
    localparam logic signed [9:0]     VMAX_N   = -VMAX_P;
    localparam logic signed [9:0]     FRIC     = 10'(FRICTION);
    localparam logic [7:0]            DZ       = 8'(DEADZONE);

    // Dead zone, scaling and direction of one raw reading.
    function automatic logic signed [8:0] accel_of(input logic [8:0] raw);
        logic [7:0]        mag;
        logic signed [8:0] a_s;
        mag = raw[7:0];
        if (mag < DZ) begin
            a_s = '0;
        end else begin
            a_s = {1'b0, ((mag - DZ) >> ACCEL_SHIFT)};
        end
        return raw[8] ? a_s : -a_s;
    endfunction

    // Velocity integration with saturation; friction only when a == 0 and it
    // stops at zero rather than flipping the sign.
    function automatic logic signed [8:0] vel_next(input logic signed [8:0] v,
                                                   input logic signed [8:0] a);
        logic signed [9:0] v_w;
        logic signed [9:0] sum;
        v_w = {v[8], v};
        sum = '0;
        if (a != 9'sd0) begin
            sum = v_w + {a[8], a};
            if (sum > VMAX_P) begin
                sum = VMAX_P;
            end else if (sum < VMAX_N) begin
                sum = VMAX_N;
            end
        end else if (v_w > 10'sd0) begin
            sum = v_w - FRIC;
            if (sum < 10'sd0) begin
                sum = '0;
            end
        end else if (v_w < 10'sd0) begin
            sum = v_w + FRIC;
            if (sum > 10'sd0) begin
                sum = '0;
            end
        end
        return sum[8:0];
    endfunction

    logic [8:0]           acc_in [2];
    logic [1:0]           blk_in;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tick_q, tick_d;
    logic                 s1_vld_q, s1_vld_d;
    logic                 s2_vld_q, s2_vld_d;
    logic signed [8:0]    acc_a_q [2];
    logic signed [8:0]    acc_a_d [2];
    logic signed [8:0]    vel_q   [2];
    logic signed [8:0]    vel_d   [2];
    logic signed [PW-1:0] pos_q   [2];
    logic signed [PW-1:0] pos_d   [2];
    logic [1:0]           inc_q, inc_d;
    logic [1:0]           dec_q, dec_d;

    assign acc_in[0] = accel_x;
    assign acc_in[1] = accel_y;
    assign blk_in    = {blk_y, blk_x};

    always_comb begin
        logic signed [PW-1:0] psum;
        psum     = '0;
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        // tick is registered from the next count so it lines up with
        // cnt_q == TICK_DIV-1 without a combinational output.
        tick_d   = (cnt_d == CNT_LAST);
        s1_vld_d = tick_q;
        s2_vld_d = s1_vld_q;
        inc_d    = '0;
        dec_d    = '0;
        for (int i = 0; i < 2; i++) begin
            acc_a_d[i] = tick_q ? accel_of(acc_in[i]) : acc_a_q[i];
            vel_d[i]   = vel_q[i];
            pos_d[i]   = pos_q[i];
            if (s1_vld_q) begin
                vel_d[i] = blk_in[i] ? '0 : vel_next(vel_q[i], acc_a_q[i]);
            end
            if (s2_vld_q) begin
                if (blk_in[i]) begin
                    pos_d[i] = '0;
                end else begin
                    psum = pos_q[i] + {{(PW-9){vel_q[i][8]}}, vel_q[i]};
                    if (psum >= STEP_P) begin
                        pos_d[i] = psum - STEP_P;
                        inc_d[i] = 1'b1;
                    end else if (psum <= STEP_N) begin
                        pos_d[i] = psum + STEP_P;
                        dec_d[i] = 1'b1;
                    end else begin
                        pos_d[i] = psum;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            tick_q   <= 1'b0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            inc_q    <= '0;
            dec_q    <= '0;
            for (int i = 0; i < 2; i++) begin
                acc_a_q[i] <= '0;
                vel_q[i]   <= '0;
                pos_q[i]   <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            inc_q    <= inc_d;
            dec_q    <= dec_d;
            for (int i = 0; i < 2; i++) begin
                acc_a_q[i] <= acc_a_d[i];
                vel_q[i]   <= vel_d[i];
                pos_q[i]   <= pos_d[i];
            end
        end
    end

    assign tick  = tick_q;
    assign x_inc = inc_q[0];
    assign x_dec = dec_q[0];
    assign y_inc = inc_q[1];
    assign y_dec = dec_q[1];
    assign vel_x = vel_q[0];
    assign vel_y = vel_q[1];

endmodule

// File: doc/tilt_motion_ctl.md
# tilt_motion_ctl

Converts the accelerometer controller's 9-bit per-axis tilt readings into physically plausible ball motion: per-axis velocity integration, dead zone, friction and saturation. Emits single-cycle step pulses that drive the ball module's `x_increment`/`x_decrement`/`y_increment`/`y_decrement` inputs. Sits between the accelerometer controller (upstream) and the ball module (downstream) in the top level. Replaces the direct sign-bit wiring, so that larger tilt means faster, accelerating movement.

## Interface
Parameters:
- `TICK_DIV`, 1000000: clk cycles per physics update (100 Hz at 100 MHz); minimum 4.
- `DEADZONE`, 8: tilt magnitudes below this produce zero acceleration.
- `ACCEL_SHIFT`, 3: right-shift applied to (magnitude − DEADZONE).
- `VMAX`, 127: velocity magnitude limit; must be < 2^FRAC_BITS and ≤ 255.
- `FRICTION`, 1: velocity decay per tick when acceleration is zero.
- `FRAC_BITS`, 10: position sub-step resolution; one step = 2^FRAC_BITS.

Ports:
- `clk`, in, 1: system clock, 100 MHz.
- `reset`, in, 1: synchronous, active-low reset.
- `accel_x`, in, 9: bit 8 is direction (1 = increment direction); bits 7:0 are magnitude.
- `accel_y`, in, 9: same format as `accel_x`.
- `blk_x`, in, 1: X movement blocked (wall); level-sensitive.
- `blk_y`, in, 1: Y movement blocked; level-sensitive.
- `x_inc`, out, 1: one-cycle step pulse, +X.
- `x_dec`, out, 1: one-cycle step pulse, −X.
- `y_inc`, out, 1: one-cycle step pulse, +Y.
- `y_dec`, out, 1: one-cycle step pulse, −Y.
- `vel_x`, out, 9: current X velocity, two's complement (debug/seven-seg).
- `vel_y`, out, 9: current Y velocity, two's complement.
- `tick`, out, 1: one-cycle pulse marking each physics update.

## Operation
- Tick counter runs 0..TICK_DIV−1 and wraps. `tick` is high on the cycle the counter equals TICK_DIV−1.
- Each tick starts a 3-stage update, identical and independent per axis.
- **S1 (accel):** register `accel_*`.
  - a = 0 if mag < DEADZONE.
  - Otherwise a = (mag − DEADZONE) >> ACCEL_SHIFT.
  - a is negated when bit 8 = 0.
  - a is signed 9-bit.
- **S2 (velocity):**
  - If blk = 1: v ← 0.
  - Else if a ≠ 0: v ← sat(v + a, ±VMAX).
  - Else: v moves toward 0 by FRICTION, clamped at 0 so it never crosses sign.
  - Sum is computed in 10 bits before saturation.
- **S3 (position):**
  - If blk = 1: p ← 0, no pulse.
  - Else p' = p + v.
    - If p' ≥ 2^FRAC_BITS: p ← p' − 2^FRAC_BITS, inc pulse.
    - If p' ≤ −2^FRAC_BITS: p ← p' + 2^FRAC_BITS, dec pulse.
    - Otherwise p ← p'.
  - p is signed FRAC_BITS+2 bits.
  - At most one pulse per axis per tick, guaranteed by VMAX < 2^FRAC_BITS.
  - inc and dec are never high together.
- `blk_*` is sampled in S2 and S3 of the same tick. Blocking one axis never affects the other.
- Direction reversal needs no special case: signed accumulation carries the residual p across zero.

## Timing
- Tick asserted at cycle N.
- S1 registers update at N+1.
- S2 (`vel_*` visible) at N+2.
- S3 pulses are high exactly during cycle N+3, registered.
- Because TICK_DIV ≥ 4, a new tick never overlaps an in-flight update.
- `accel_*` is sampled only at the N→N+1 edge; changes between ticks are ignored.
- Reset (reset = 0 at a rising edge) forces the following to 0 on the next cycle, all via registered outputs:
  - the counter;
  - all stage registers;
  - v and p;
  - `x_inc`, `x_dec`, `y_inc`, `y_dec`, `vel_x`, `vel_y` and `tick`.
- Reset mid-update discards the pending stages; no pulse is emitted afterwards for that tick.
- After reset release, the first `tick` occurs TICK_DIV−1 cycles later.

## Test plan
Use TICK_DIV = 4 and all other parameters at their defaults.

1. **Acceleration:** hold accel_x = {1, 8'd40} (a = +4). Required: `vel_x` steps 4, 8, 12, …; the first `x_inc` pulse comes on tick 23 (cumulative 1104 ≥ 1024); `x_dec`, `y_*` and `vel_y` stay 0.
2. **Saturation and reversal:** continue test 1 to tick 32. Required: `vel_x` = 127 (clipped, not 128) and thereafter exactly one `x_inc` per ⌈1024/127⌉-ish cadence. Then apply accel_x = {0, 8'd40}. Required: `vel_x` 123, 119, …, crosses to negative, and `x_dec` pulses begin; never both pulses in one cycle.
3. **Friction and dead zone:** preload `vel_x` = 10, then apply accel_x = {1, 8'd7}, which is below DEADZONE. Required: `vel_x` 9, 8, …, 0, then stays 0 with no undershoot.
4. **Blocking:** `vel_x` = 60 with p nonzero; assert `blk_x` for one tick. Required: `vel_x` = 0 at N+2, no `x_*` pulse that tick, p cleared; `vel_y` and `y_*` pulses unaffected.
5. **Reset mid-update:** drive reset = 0 at cycle N+2 of a tick that would produce `x_inc`. Required: no pulse at N+3, and all outputs 0 the cycle after the reset edge.
6. **Timing alignment:** check that `tick`-to-pulse latency is exactly 3 cycles, and that each pulse is exactly 1 cycle wide.
